// File: rtl/load_store_unit.sv
// Data-memory access stage: one registered request/ack transaction per load/store,
// with lane steering, load extension, illegal-access flagging and bus timeout.
//
// state  | meaning
// IDLE   | waiting for memRead/memWrite; illegal requests pulse misaligned
// BUSY   | bus request outstanding, core stalled, timeout counter running
// DONE   | transaction retired; core advances, bus requests dropped
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic        stall,
  output logic        misaligned,
  output logic        busError,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [3:0]  busByteEn,
  output logic        busRead,
  output logic        busWrite,
  input  logic [31:0] busRData,
  input  logic        busAck
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter starts at 0 on BUSY entry, so the last waiting cycle holds TIMEOUT_CYCLES-1.
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_load_data;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_bus_read;
  logic        r_bus_write;
  logic        r_misaligned;
  logic        r_bus_error;

  logic        w_req;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_legal;
  logic        w_accept;
  logic        w_reject;
  logic        w_timeout;
  logic        w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;

  assign w_req = memRead | memWrite;

  always_comb begin
    w_f3_ok = 1'b0;
    if (memRead) begin
      case (funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_f3_ok = 1'b1;
        default:                      w_f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'd0, 3'd1, 3'd2: w_f3_ok = 1'b1;
        default:          w_f3_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_align_ok = 1'b1;
    case (funct3[1:0])
      2'd1:    w_align_ok = ~ALUResult[0];
      2'd2:    w_align_ok = (ALUResult[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  assign w_legal = ~(memRead & memWrite) & w_f3_ok & w_align_ok;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = storeData;
    case (funct3[1:0])
      2'd0: begin
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{storeData[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << ALUResult[1:0];
        w_wdata = {2{storeData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = storeData;
      end
    endcase
  end

  assign w_shifted = busRData >> {r_addr_lo, 3'b000};

  always_comb begin
    w_ext = busRData;
    case (r_funct3)
      3'd0:    w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'd1:    w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd4:    w_ext = {24'h000000, w_shifted[7:0]};
      3'd5:    w_ext = {16'h0000, w_shifted[15:0]};
      default: w_ext = busRData;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_timeout = 1'b0;
    w_stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_legal) begin
            w_accept = 1'b1;
            w_stall  = 1'b1;
            w_next   = S_BUSY;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (busAck) begin
          w_next = S_DONE;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt        <= 10'd0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_load_data  <= 32'd0;
      r_bus_addr   <= 32'd0;
      r_bus_wdata  <= 32'd0;
      r_bus_be     <= 4'd0;
      r_bus_read   <= 1'b0;
      r_bus_write  <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_misaligned <= w_reject;
      r_bus_error  <= w_timeout;
      if (w_accept) begin
        r_bus_addr  <= {ALUResult[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
        r_bus_read  <= memRead;
        r_bus_write <= memWrite;
        r_funct3    <= funct3;
        r_addr_lo   <= ALUResult[1:0];
        r_cnt       <= 10'd0;
      end
      if (r_state == S_BUSY) begin
        if (busAck || w_timeout) begin
          r_bus_read  <= 1'b0;
          r_bus_write <= 1'b0;
          if (busAck && r_bus_read) r_load_data <= w_ext;
        end else begin
          r_cnt <= r_cnt + 10'd1;
        end
      end
    end
  end

  assign loadData   = r_load_data;
  assign stall      = w_stall;
  assign misaligned = r_misaligned;
  assign busError   = r_bus_error;
  assign busAddr    = r_bus_addr;
  assign busWData   = r_bus_wdata;
  assign busByteEn  = r_bus_be;
  assign busRead    = r_bus_read;
  assign busWrite   = r_bus_write;

endmodule
